// File: rtl/spi_led_ctrl.sv
// Command executor behind spi_slave: per-LED brightness registers, PWM drive and read responses.
// Optional build macro LED_FADE_EN: applied level ramps toward the written target one step per FADE_TICKS.
//
// state   | meaning
// IDLE    | waiting for a decoded frame
// DECODE  | classify latched cmd/addr; write, read response or error is committed leaving here
// EXEC_WR | brightness write visible, return to IDLE
// EXEC_RD | read response loaded, proceed to RESP
// RESP    | tx_enb held with o_frame stable until cs deasserts
module spi_led_ctrl #(
    parameter int NUM_LEDS     = 4,
    parameter int PWM_PRESCALE = 1250,
    parameter int MAX_LEVEL    = 100,
`ifdef LED_FADE_EN
    parameter int FADE_TICKS   = 125000,
`endif
    parameter logic CS_ASSERT  = 1'b0
) (
    input  logic                sysclk,
    input  logic                rst_n,
    input  logic                cs,
    input  logic                frame_valid,
    input  logic [7:0]          i_cmd,
    input  logic [7:0]          i_addr,
    input  logic [7:0]          i_payload,
    output logic                tx_enb,
    output logic [23:0]         o_frame,
    output logic [NUM_LEDS-1:0] led_pwm,
    output logic                cmd_err
);

    localparam logic [7:0] CMD_NOP   = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    localparam int         IDX_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [7:0] NUM_LEDS_B = 8'(NUM_LEDS);
    localparam logic [7:0] LEVEL_MAX  = 8'(MAX_LEVEL);
    localparam logic [7:0] STEP_LAST  = 8'(MAX_LEVEL - 1);
    localparam int         PRESC_W    = $clog2(PWM_PRESCALE + 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PWM_PRESCALE - 1);

    typedef enum logic [2:0] {IDLE, DECODE, EXEC_WR, EXEC_RD, RESP} state_t;

    state_t             state, state_nxt;
    logic [7:0]         cmd_q, addr_q, payload_q;
    logic [IDX_W-1:0]   idx;
    logic               cs_act, addr_ok;
    logic               do_wr, do_rd, do_err, do_clr;
    logic [7:0]         target [NUM_LEDS];
    logic [7:0]         level  [NUM_LEDS];
    logic [PRESC_W-1:0] presc;
    logic [7:0]         step;

    assign cs_act  = (cs == CS_ASSERT);
    assign addr_ok = (addr_q < NUM_LEDS_B);
    assign idx     = addr_q[IDX_W-1:0];

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_wr     = 1'b0;
        do_rd     = 1'b0;
        do_err    = 1'b0;
        do_clr    = 1'b0;
        case (state)
            IDLE: if (frame_valid) state_nxt = DECODE;
            DECODE: begin
                if (!cs_act) begin
                    state_nxt = IDLE;
                end else if (addr_ok && cmd_q == CMD_WRITE) begin
                    state_nxt = EXEC_WR;
                    do_wr     = 1'b1;
                end else if (addr_ok && cmd_q == CMD_READ) begin
                    state_nxt = EXEC_RD;
                    do_rd     = 1'b1;
                end else if (cmd_q == CMD_NOP) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = RESP;
                    do_err    = 1'b1;
                end
            end
            EXEC_WR: state_nxt = IDLE;
            EXEC_RD: begin
                state_nxt = cs_act ? RESP : IDLE;
                do_clr    = !cs_act;
            end
            RESP: begin
                if (!cs_act) begin
                    state_nxt = IDLE;
                    do_clr    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Actions are registered on the DECODE exit edge so writes and tx_enb land two cycles after frame_valid.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q     <= '0;
            addr_q    <= '0;
            payload_q <= '0;
            tx_enb    <= 1'b0;
            o_frame   <= '0;
            cmd_err   <= 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) target[i] <= '0;
        end else begin
            cmd_err <= do_err;
            if (state == IDLE && frame_valid) begin
                cmd_q     <= i_cmd;
                addr_q    <= i_addr;
                payload_q <= i_payload;
            end
            if (do_wr)
                target[idx] <= (payload_q > LEVEL_MAX) ? LEVEL_MAX : payload_q;
            if (do_rd) begin
                tx_enb  <= 1'b1;
                o_frame <= {CMD_READ, addr_q, target[idx]};
            end else if (do_err) begin
                tx_enb  <= 1'b1;
                o_frame <= {8'hFF, addr_q, 8'h00};
            end else if (do_clr) begin
                tx_enb  <= 1'b0;
                o_frame <= '0;
            end
        end
    end

`ifdef LED_FADE_EN
    localparam int FADE_W = $clog2(FADE_TICKS + 1);
    localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_TICKS - 1);
    logic [FADE_W-1:0] fade_cnt;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            fade_cnt <= FADE_LAST;
            for (int i = 0; i < NUM_LEDS; i++) level[i] <= '0;
        end else if (fade_cnt == '0) begin
            fade_cnt <= FADE_LAST;
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (level[i] < target[i])      level[i] <= level[i] + 8'd1;
                else if (level[i] > target[i]) level[i] <= level[i] - 8'd1;
            end
        end else begin
            fade_cnt <= fade_cnt - 1'b1;
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) level[i] = target[i];
    end
`endif

    // Level 0 never matches and MAX_LEVEL always matches, giving constant off/on.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            presc   <= '0;
            step    <= '0;
            led_pwm <= '0;
        end else begin
            if (presc == PRESC_LAST) begin
                presc <= '0;
                step  <= (step == STEP_LAST) ? 8'd0 : step + 8'd1;
            end else begin
                presc <= presc + 1'b1;
            end
            for (int i = 0; i < NUM_LEDS; i++) led_pwm[i] <= (step < level[i]);
        end
    end

endmodule

// File: tb/tb_spi_led_ctrl.sv
// Directed self-checking bench for spi_led_ctrl (default build, LED_FADE_EN undefined).
module tb_spi_led_ctrl;

    localparam int NUM_LEDS = 4;
    localparam int PRESCALE = 4;
    localparam int PERIOD   = PRESCALE * 100;

    logic                sysclk = 1'b0;
    logic                rst_n;
    logic                cs;
    logic                frame_valid;
    logic [7:0]          i_cmd, i_addr, i_payload;
    logic                tx_enb;
    logic [23:0]         o_frame;
    logic [NUM_LEDS-1:0] led_pwm;
    logic                cmd_err;

    int tests  = 0;
    int failed = 0;

    spi_led_ctrl #(.NUM_LEDS(NUM_LEDS), .PWM_PRESCALE(PRESCALE), .MAX_LEVEL(100)) dut (
        .sysclk(sysclk), .rst_n(rst_n), .cs(cs), .frame_valid(frame_valid),
        .i_cmd(i_cmd), .i_addr(i_addr), .i_payload(i_payload),
        .tx_enb(tx_enb), .o_frame(o_frame), .led_pwm(led_pwm), .cmd_err(cmd_err)
    );

    always #4 sysclk = ~sysclk;

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  addr;
        logic [7:0]  payload;
        logic        tx;
        logic [23:0] frame;
        logic        err;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] a, input logic [7:0] p);
        @(posedge sysclk); #1;
        frame_valid = 1'b1; i_cmd = c; i_addr = a; i_payload = p;
        @(posedge sysclk); #1;
        frame_valid = 1'b0;
    endtask

    task automatic release_cs(input string name);
        cs = 1'b1;
        @(posedge sysclk); #1;
        check({name, " tx_off"}, 32'(tx_enb), 32'd0);
        check({name, " frame_clr"}, 32'(o_frame), 32'd0);
        cs = 1'b0;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        send(v.cmd, v.addr, v.payload);
        @(posedge sysclk); #1;
        check({name, " tx"}, 32'(tx_enb), 32'(v.tx));
        check({name, " frame"}, 32'(o_frame), 32'(v.frame));
        check({name, " err"}, 32'(cmd_err), 32'(v.err));
        @(posedge sysclk); #1;
        check({name, " err_pulse"}, 32'(cmd_err), 32'd0);
        if (v.tx) begin
            check({name, " tx_hold"}, 32'(tx_enb), 32'd1);
            release_cs(name);
        end
    endtask

    task automatic count_pwm(input int led, input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge sysclk); #1;
            if (led_pwm[led]) cnt++;
        end
    endtask

    vec_t v;
    int   cnt;

    initial begin
        vecs[0]  = '{8'h01, 8'h02, 8'h32, 1'b0, 24'h000000, 1'b0};
        vecs[1]  = '{8'h02, 8'h02, 8'h00, 1'b1, 24'h020232, 1'b0};
        vecs[2]  = '{8'h01, 8'h00, 8'hC8, 1'b0, 24'h000000, 1'b0};
        vecs[3]  = '{8'h02, 8'h00, 8'h5A, 1'b1, 24'h020064, 1'b0};
        vecs[4]  = '{8'h02, 8'h07, 8'h00, 1'b1, 24'hFF0700, 1'b1};
        vecs[5]  = '{8'h03, 8'h01, 8'h11, 1'b1, 24'hFF0100, 1'b1};
        vecs[6]  = '{8'h00, 8'h01, 8'h55, 1'b0, 24'h000000, 1'b0};
        vecs[7]  = '{8'h02, 8'h01, 8'h00, 1'b1, 24'h020100, 1'b0};
        vecs[8]  = '{8'h01, 8'h03, 8'h63, 1'b0, 24'h000000, 1'b0};
        vecs[9]  = '{8'h02, 8'h03, 8'h00, 1'b1, 24'h020363, 1'b0};
        vecs[10] = '{8'h01, 8'h01, 8'h65, 1'b0, 24'h000000, 1'b0};
        vecs[11] = '{8'h02, 8'h01, 8'h00, 1'b1, 24'h020164, 1'b0};
        vecs[12] = '{8'h01, 8'h04, 8'h10, 1'b1, 24'hFF0400, 1'b1};
        vecs[13] = '{8'h02, 8'h02, 8'h00, 1'b1, 24'h020232, 1'b0};

        rst_n = 1'b0; cs = 1'b1; frame_valid = 1'b0;
        i_cmd = '0; i_addr = '0; i_payload = '0;
        repeat (3) @(posedge sysclk);
        #1;
        check("reset tx_enb", 32'(tx_enb), 32'd0);
        check("reset o_frame", 32'(o_frame), 32'd0);
        check("reset led_pwm", 32'(led_pwm), 32'd0);
        check("reset cmd_err", 32'(cmd_err), 32'd0);
        @(negedge sysclk);
        rst_n = 1'b1;
        cs    = 1'b0;

        for (int i = 0; i < 14; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        count_pwm(2, PERIOD, cnt);
        check("pwm led2 duty50", 32'(cnt), 32'd200);
        count_pwm(0, 3 * PERIOD, cnt);
        check("pwm led0 full", 32'(cnt), 32'(3 * PERIOD));
        count_pwm(3, PERIOD, cnt);
        check("pwm led3 duty99", 32'(cnt), 32'd396);

        v = '{8'h01, 8'h01, 8'h00, 1'b0, 24'h000000, 1'b0};
        run_vec("wr led1 0", v);
        repeat (2) @(posedge sysclk);
        count_pwm(1, 3 * PERIOD, cnt);
        check("pwm led1 off", 32'(cnt), 32'd0);
        v = '{8'h01, 8'h01, 8'h64, 1'b0, 24'h000000, 1'b0};
        run_vec("wr led1 100", v);
        repeat (2) @(posedge sysclk);
        count_pwm(1, 3 * PERIOD, cnt);
        check("pwm led1 on", 32'(cnt), 32'(3 * PERIOD));

        // Frame arriving during RESP must be dropped.
        send(8'h02, 8'h02, 8'h00);
        @(posedge sysclk); #1;
        check("resp tx", 32'(tx_enb), 32'd1);
        send(8'h01, 8'h02, 8'h00);
        repeat (3) @(posedge sysclk);
        #1;
        check("drop tx", 32'(tx_enb), 32'd1);
        check("drop frame", 32'(o_frame), 32'h020232);
        release_cs("drop");
        v = '{8'h02, 8'h02, 8'h00, 1'b1, 24'h020232, 1'b0};
        run_vec("drop readback", v);

        // Asynchronous reset while holding a response.
        send(8'h02, 8'h00, 8'h00);
        @(posedge sysclk); #1;
        check("pre-rst frame", 32'(o_frame), 32'h020064);
        #1 rst_n = 1'b0;
        #1;
        check("async rst tx", 32'(tx_enb), 32'd0);
        check("async rst frame", 32'(o_frame), 32'd0);
        @(negedge sysclk);
        rst_n = 1'b1;
        v = '{8'h02, 8'h02, 8'h00, 1'b1, 24'h020200, 1'b0};
        run_vec("post-rst read", v);
        repeat (2) @(posedge sysclk);
        #1;
        check("post-rst pwm", 32'(led_pwm), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
